pipeline_restoring_divider: RTL and testbench



---
 rtl/pipeline_div_pkg.sv | 32 +++
 rtl/div_restore_step.sv | 29 ++
 rtl/pipeline_restoring_divider.sv | 125 ++++++++++++
 tb/tb_pipeline_restoring_divider.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_div_pkg.sv
// ============================================================================
// Module   : pipeline_div_pkg
// Brief    : Shared constants, latency helper and per-stage control struct
//            for the pipelined restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_div_pkg;

    localparam int C_DEFAULT_WIDTH = 8;

    // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
    localparam logic [63:0] C_DBZ_QUOTIENT = '1;

    function automatic int latency(input int width);
        return width + 2;
    endfunction

    // Width-independent part of a stage; the data fields are added by the
    // parent, which knows WIDTH.
    typedef struct packed {
        logic valid;
        logic dvd_neg;
        logic q_neg;
        logic dbz;
        logic ovf;
    } div_ctl_t;

endpackage

`default_nettype wire

// File: rtl/div_restore_step.sv
// ============================================================================
// Module   : div_restore_step
// Brief    : One combinational restoring-division step: shift in a dividend
//            bit, subtract the divisor if it fits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r,
    output logic             o_qbit
);

    logic [WIDTH-1:0] w_shift;

    // The subtraction only needs the low WIDTH bits: the result is below the
    // divisor whenever it is kept, so the dropped MSB is always zero.
    assign w_shift = {i_r[WIDTH-2:0], i_bit};
    assign o_qbit  = ({i_r, i_bit} >= {1'b0, i_d});
    assign o_r     = o_qbit ? (w_shift - i_d) : w_shift;

endmodule

`default_nettype wire

// File: rtl/pipeline_restoring_divider.sv
// ============================================================================
// Module   : pipeline_restoring_divider
// Brief    : Fully pipelined restoring divider, one pair per clock, latency
//            WIDTH+2. Signed mode enabled by PIPELINE_DIVIDER_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_restoring_divider
    import pipeline_div_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    // qd holds the not-yet-consumed dividend bits in its upper part while
    // quotient bits shift in from the bottom.
    typedef struct packed {
        div_ctl_t         ctl;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] qd;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] raw;
    } stage_t;

    stage_t r_stage [0:WIDTH];
    stage_t w_next  [1:WIDTH];
    stage_t w_s0;
    stage_t w_last;

`ifdef PIPELINE_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    always_comb begin
        w_s0           = '0;
        w_s0.ctl.valid = in_valid;
        w_s0.ctl.dbz   = (divisor == '0);
        w_s0.raw       = dividend;
`ifdef PIPELINE_DIVIDER_SIGNED_EN
        w_s0.ctl.dvd_neg = dividend[WIDTH-1];
        w_s0.ctl.q_neg   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
        w_s0.ctl.ovf     = (dividend == C_MOST_NEG) && (divisor == '1);
        w_s0.qd          = dividend[WIDTH-1] ? -dividend : dividend;
        w_s0.d           = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
        w_s0.qd = dividend;
        w_s0.d  = divisor;
`endif
    end

    for (genvar k = 1; k <= WIDTH; k++) begin : g_step
        logic [WIDTH-1:0] w_r;
        logic             w_qbit;

        div_restore_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .i_r    (r_stage[k-1].r),
            .i_bit  (r_stage[k-1].qd[WIDTH-1]),
            .i_d    (r_stage[k-1].d),
            .o_r    (w_r),
            .o_qbit (w_qbit)
        );

        assign w_next[k].ctl = r_stage[k-1].ctl;
        assign w_next[k].r   = w_r;
        assign w_next[k].qd  = {r_stage[k-1].qd[WIDTH-2:0], w_qbit};
        assign w_next[k].d   = r_stage[k-1].d;
        assign w_next[k].raw = r_stage[k-1].raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= WIDTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= w_s0;
            for (int k = 1; k <= WIDTH; k++) begin
                r_stage[k] <= w_next[k];
            end
        end
    end

    assign w_last = r_stage[WIDTH];

    // In unsigned builds the sign bits are constant zero, so the negations
    // below reduce to plain pass-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            out_valid <= w_last.ctl.valid;
            if (w_last.ctl.valid) begin
                if (w_last.ctl.dbz) begin
                    quotient  <= C_DBZ_QUOTIENT[WIDTH-1:0];
                    remainder <= w_last.raw;
                end else begin
                    quotient  <= w_last.ctl.q_neg   ? -w_last.qd : w_last.qd;
                    remainder <= w_last.ctl.dvd_neg ? -w_last.r  : w_last.r;
                end
                div_by_zero <= w_last.ctl.dbz;
                overflow    <= w_last.ctl.ovf;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_restoring_divider.sv
// ============================================================================
// Module   : tb_pipeline_restoring_divider
// Brief    : Self-checking bench for pipeline_restoring_divider (WIDTH=8),
//            follows PIPELINE_DIVIDER_SIGNED_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipeline_restoring_divider;

    localparam int W   = 8;
    localparam int LAT = W + 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    pipeline_restoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int           due;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    logic         chk_en = 1'b0;
    logic [W-1:0] last_q, last_r;
    logic         last_dbz, last_ovf;

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz, output logic ovf);
        int sa, sb_i;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 0) begin
            q   = 8'hFF;
            r   = a;
            dbz = 1'b1;
        end
`ifdef PIPELINE_DIVIDER_SIGNED_EN
        else if (a == 8'h80 && b == 8'hFF) begin
            q   = 8'h80;
            r   = 8'h00;
            ovf = 1'b1;
        end else begin
            sa   = int'($signed(a));
            sb_i = int'($signed(b));
            q    = 8'(sa / sb_i);
            r    = 8'(sa % sb_i);
        end
`else
        else begin
            sa   = int'(a);
            sb_i = int'(b);
            q    = 8'(sa / sb_i);
            r    = 8'(sa % sb_i);
        end
`endif
    endfunction

    // Drive one cycle; the pair is sampled at the next edge and appears
    // LAT edges after the current one.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic use_lit, input exp_t lit);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        dividend = a;
        divisor  = b;
        if (v) begin
            if (use_lit) e = lit;
            else model(a, b, e.q, e.r, e.dbz, e.ovf);
            e.due = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic edbz, input logic eovf);
        exp_t lit, m;
        lit.q = eq; lit.r = er; lit.dbz = edbz; lit.ovf = eovf; lit.due = 0;
        model(a, b, m.q, m.r, m.dbz, m.ovf);
        chk("model_pin", {m.q, m.r, 6'd0, m.dbz, m.ovf}, {eq, er, 6'd0, edbz, eovf});
        drive(1'b1, a, b, 1'b1, lit);
    endtask

    task automatic bubble();
        exp_t nil;
        nil = '{due: 0, q: '0, r: '0, dbz: 1'b0, ovf: 1'b0};
        drive(1'b0, 8'h00, 8'h00, 1'b0, nil);
    endtask

    task automatic clear_model();
        sb.delete();
        last_q = '0; last_r = '0; last_dbz = 1'b0; last_ovf = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                chk("result_late", 32'(sb[0].due), 32'(cyc));
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("out_valid", out_valid, 1);
                chk("quotient", quotient, sb[0].q);
                chk("remainder", remainder, sb[0].r);
                chk("div_by_zero", div_by_zero, sb[0].dbz);
                chk("overflow", overflow, sb[0].ovf);
                last_q = sb[0].q; last_r = sb[0].r;
                last_dbz = sb[0].dbz; last_ovf = sb[0].ovf;
                void'(sb.pop_front());
            end else begin
                chk("out_valid_idle", out_valid, 0);
                chk("hold_outputs", {quotient, remainder, 6'd0, div_by_zero, overflow},
                    {last_q, last_r, 6'd0, last_dbz, last_ovf});
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_quotient"}, quotient, 0);
        chk({tag, "_remainder"}, remainder, 0);
        chk({tag, "_div_by_zero"}, div_by_zero, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        exp_t nil;
        nil = '{due: 0, q: '0, r: '0, dbz: 1'b0, ovf: 1'b0};
        rst_n = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0;
        clear_model();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

`ifdef PIPELINE_DIVIDER_SIGNED_EN
        directed(8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 1'b0);
        directed(8'h9C,  8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0);
        directed(8'd7,   8'h9C, 8'h00, 8'h07, 1'b0, 1'b0);
        directed(8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
        directed(8'h80,  8'h01, 8'h80, 8'h00, 1'b0, 1'b0);
        directed(8'd37,  8'h00, 8'hFF, 8'd37, 1'b1, 1'b0);
        directed(8'hDB,  8'h00, 8'hFF, 8'hDB, 1'b1, 1'b0);
        directed(8'hF9,  8'hFE, 8'h03, 8'hFF, 1'b0, 1'b0);
`else
        directed(8'd200, 8'd3,   8'd66,  8'd2,  1'b0, 1'b0);
        directed(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 1'b0);
        directed(8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 1'b0);
        directed(8'd128, 8'd255, 8'd0,   8'd128, 1'b0, 1'b0);
        directed(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 1'b0);
`endif
        bubble();
        bubble();

        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 9))
                0: b = 8'h00;
                1: b = 8'hFF;
                2: a = 8'h80;
                3: begin a = 8'h80; b = 8'hFF; end
                default: ;
            endcase
            drive($urandom_range(0, 4) != 0, a, b, 1'b0, nil);
        end
        repeat (LAT + 2) bubble();
        chk("drain_empty", 32'(sb.size()), 0);

        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'd50 + i), 8'd3, 1'b0, nil);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        in_valid = 1'b0;
        clear_model();
        #1 check_zero_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("held_reset");
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        drive(1'b1, 8'd90, 8'd4, 1'b0, nil);
        repeat (LAT + 2) bubble();
        chk("post_reset_drain", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
